// File: rtl/uc_bcast_scheduler.sv
// Round-robin scheduler from engine implied-literal queue heads onto the shared unit-clause
// broadcast path, with per-level duplicate/negation filtering and UCQ_OUT credit gating.
module uc_bcast_scheduler #(
    parameter int unsigned NUM_ENG   = 4,
    parameter int unsigned LIT_W     = 8,
    parameter int unsigned UCQ_DEPTH = 4,
    parameter int unsigned CAM_DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_ENG-1:0]       i_eng_valid,
    input  logic [NUM_ENG*LIT_W-1:0] i_eng_lit,
    output logic [NUM_ENG-1:0]       o_eng_pop,
    output logic                     o_ucq_push,
    output logic [LIT_W-1:0]         o_ucq_lit,
    input  logic [NUM_ENG-1:0]       i_ucq_credit_ret,
    input  logic                     i_lvl_clear,
    output logic                     o_conflict,
    input  logic                     i_conflict_ack,
    output logic                     o_stall,
    output logic [15:0]              o_dup_cnt
);

    localparam int unsigned PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int unsigned CRD_W = $clog2(UCQ_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(CAM_DEPTH + 1);
    localparam int unsigned IDX_W = (CAM_DEPTH > 1) ? $clog2(CAM_DEPTH) : 1;

    typedef enum logic [0:0] {StRun, StConflict} state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CRD_W-1:0]   r_credit [NUM_ENG];
    logic [LIT_W-1:0]   r_hist [CAM_DEPTH];
    logic [CNT_W-1:0]   r_hist_cnt;
    logic               r_push;
    logic [LIT_W-1:0]   r_lit;
    logic [15:0]        r_dup_cnt;

    logic               w_cred_ok;
    logic               w_eligible;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_grant;
    logic [LIT_W-1:0]   w_gnt_lit;
    logic [LIT_W-1:0]   w_neg_lit;
    logic               w_hit_dup;
    logic               w_hit_neg;
    logic               w_is_null;
    logic               w_new;
    logic               w_dup;
    logic               w_neg;
    logic               w_hist_clr;

    always_comb begin
        w_cred_ok = 1'b1;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (r_credit[i] == '0) w_cred_ok = 1'b0;
        end
    end

    assign w_eligible = (r_state == StRun) && !i_lvl_clear && w_cred_ok &&
                        (r_hist_cnt < CNT_W'(CAM_DEPTH));

    // Pointer arithmetic wraps naturally because NUM_ENG is a power of two.
    always_comb begin
        logic [PTR_W-1:0] v_cand;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        v_cand    = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            v_cand = r_rr_ptr + PTR_W'(k);
            if (!w_gnt_vld && i_eng_valid[v_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_cand;
            end
        end
    end

    assign w_grant   = w_eligible && w_gnt_vld && !i_rst;
    assign w_gnt_lit = i_eng_lit[w_gnt_idx*LIT_W +: LIT_W];
    assign w_neg_lit = {~w_gnt_lit[LIT_W-1], w_gnt_lit[LIT_W-2:0]};
    assign w_is_null = (w_gnt_lit == '0);

    always_comb begin
        w_hit_dup = 1'b0;
        w_hit_neg = 1'b0;
        for (int e = 0; e < CAM_DEPTH; e++) begin
            if (CNT_W'(e) < r_hist_cnt) begin
                if (r_hist[e] == w_gnt_lit) w_hit_dup = 1'b1;
                if (r_hist[e] == w_neg_lit) w_hit_neg = 1'b1;
            end
        end
    end

    assign w_neg = w_grant && !w_is_null && w_hit_neg;
    assign w_dup = w_grant && !w_is_null && w_hit_dup && !w_hit_neg;
    assign w_new = w_grant && !w_is_null && !w_hit_dup && !w_hit_neg;

    assign w_hist_clr = i_lvl_clear || ((r_state == StConflict) && i_conflict_ack);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StRun:      if (w_neg) w_state_d = StConflict;
            StConflict: if (i_conflict_ack) w_state_d = StRun;
            default:    w_state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StRun;
            r_rr_ptr   <= '0;
            r_hist_cnt <= '0;
            r_push     <= 1'b0;
            r_lit      <= '0;
            r_dup_cnt  <= '0;
            for (int i = 0; i < NUM_ENG; i++) r_credit[i] <= CRD_W'(UCQ_DEPTH);
            for (int e = 0; e < CAM_DEPTH; e++) r_hist[e] <= '0;
        end else begin
            r_state <= w_state_d;
            r_push  <= w_new;
            if (w_new) r_lit <= w_gnt_lit;
            if (w_grant) r_rr_ptr <= w_gnt_idx + PTR_W'(1);
            if (w_dup && (r_dup_cnt != 16'hFFFF)) r_dup_cnt <= r_dup_cnt + 16'd1;

            if (w_hist_clr) begin
                r_hist_cnt <= '0;
            end else if (w_new) begin
                r_hist[r_hist_cnt[IDX_W-1:0]] <= w_gnt_lit;
                r_hist_cnt                    <= r_hist_cnt + CNT_W'(1);
            end

            // A return and a debit in the same cycle cancel; returns saturate at full depth.
            for (int i = 0; i < NUM_ENG; i++) begin
                if (w_new && !i_ucq_credit_ret[i]) begin
                    r_credit[i] <= r_credit[i] - CRD_W'(1);
                end else if (!w_new && i_ucq_credit_ret[i] &&
                             (r_credit[i] != CRD_W'(UCQ_DEPTH))) begin
                    r_credit[i] <= r_credit[i] + CRD_W'(1);
                end
            end
        end
    end

    assign o_eng_pop  = w_grant ? (NUM_ENG'(1) << w_gnt_idx) : '0;
    assign o_ucq_push = r_push;
    assign o_ucq_lit  = r_lit;
    assign o_conflict = (r_state == StConflict);
    assign o_stall    = !w_eligible;
    assign o_dup_cnt  = r_dup_cnt;

endmodule

// File: tb/tb_uc_bcast_scheduler.sv
// Bench for uc_bcast_scheduler: directed scenarios plus randomized traffic checked against a
// queue-based model of the issue rules.
module tb_uc_bcast_scheduler;

    localparam int NE = 4;
    localparam int LW = 8;
    localparam int QD = 4;
    localparam int CD = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NE-1:0]   eng_valid;
    logic [NE*LW-1:0] eng_lit;
    logic [NE-1:0]   eng_pop;
    logic            ucq_push;
    logic [LW-1:0]   ucq_lit;
    logic [NE-1:0]   credit_ret;
    logic            lvl_clear;
    logic            conflict;
    logic            conflict_ack;
    logic            stall;
    logic [15:0]     dup_cnt;

    int checks   = 0;
    int failures = 0;

    uc_bcast_scheduler #(
        .NUM_ENG  (NE),
        .LIT_W    (LW),
        .UCQ_DEPTH(QD),
        .CAM_DEPTH(CD)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_eng_valid     (eng_valid),
        .i_eng_lit       (eng_lit),
        .o_eng_pop       (eng_pop),
        .o_ucq_push      (ucq_push),
        .o_ucq_lit       (ucq_lit),
        .i_ucq_credit_ret(credit_ret),
        .i_lvl_clear     (lvl_clear),
        .o_conflict      (conflict),
        .i_conflict_ack  (conflict_ack),
        .o_stall         (stall),
        .o_dup_cnt       (dup_cnt)
    );

    always #5 clk = ~clk;

    // Model: issued literals of the current level, credit counts, pointer, conflict flag.
    logic [LW-1:0] m_hist[$];
    int            m_cred[NE];
    int            m_rr;
    bit            m_conf;
    int            m_dup;
    bit            m_push;
    logic [LW-1:0] m_lit;

    // Prediction for the current cycle: 0 none, 1 null, 2 dup, 3 negation, 4 new.
    int            p_gnt;
    int            p_kind;
    logic [LW-1:0] p_lit;
    bit            p_stall;
    logic [NE-1:0] p_pop;

    function automatic bit in_hist(logic [LW-1:0] l);
        foreach (m_hist[j]) if (m_hist[j] == l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void predict();
        bit elig;
        int idx;
        elig = !m_conf && !lvl_clear && (m_hist.size() < CD);
        for (int i = 0; i < NE; i++) if (m_cred[i] == 0) elig = 1'b0;
        p_stall = !elig;
        p_gnt   = -1;
        p_kind  = 0;
        p_pop   = '0;
        p_lit   = '0;
        if (elig && !rst) begin
            for (int k = 0; k < NE; k++) begin
                idx = (m_rr + k) % NE;
                if (p_gnt < 0 && eng_valid[idx]) p_gnt = idx;
            end
        end
        if (p_gnt >= 0) begin
            p_pop[p_gnt] = 1'b1;
            p_lit = eng_lit[p_gnt*LW +: LW];
            if (p_lit == '0) p_kind = 1;
            else if (in_hist(p_lit ^ 8'h80)) p_kind = 3;
            else if (in_hist(p_lit)) p_kind = 2;
            else p_kind = 4;
        end
    endfunction

    function automatic void commit();
        bit was_conf;
        bit dec;
        if (rst) begin
            m_hist.delete();
            for (int i = 0; i < NE; i++) m_cred[i] = QD;
            m_rr = 0; m_conf = 0; m_dup = 0; m_push = 0; m_lit = '0;
        end else begin
            was_conf = m_conf;
            dec      = (p_kind == 4);
            if (p_gnt >= 0) m_rr = (p_gnt + 1) % NE;
            for (int i = 0; i < NE; i++) begin
                if (dec && !credit_ret[i]) m_cred[i]--;
                else if (!dec && credit_ret[i] && m_cred[i] < QD) m_cred[i]++;
            end
            m_push = dec;
            if (dec) m_lit = p_lit;
            if (p_kind == 2 && m_dup < 65535) m_dup++;
            if (lvl_clear || (was_conf && conflict_ack)) m_hist.delete();
            if (dec) m_hist.push_back(p_lit);
            if (p_kind == 3) m_conf = 1'b1;
            else if (was_conf && conflict_ack) m_conf = 1'b0;
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        predict();
    endtask

    task automatic advance();
        @(posedge clk);
        predict();
        commit();
        #1;
    endtask

    task automatic set_lit(input int e, input logic [LW-1:0] v);
        eng_lit[e*LW +: LW] = v;
    endtask

    task automatic idle_inputs();
        eng_valid = '0; eng_lit = '0; credit_ret = '0; lvl_clear = 1'b0; conflict_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if ({eng_pop, ucq_push, ucq_lit, conflict, stall, dup_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state got pop=%b push=%b lit=%h conf=%b stall=%b dup=%0d exp all 0",
                     eng_pop, ucq_push, ucq_lit, conflict, stall, dup_cnt);
        end
        advance();
    endtask

    task automatic test_rr();
        do_reset();
        eng_valid = 4'hF;
        for (int e = 0; e < NE; e++) set_lit(e, LW'(e + 1));
        for (int k = 0; k < NE; k++) begin
            settle();
            checks++;
            if (eng_pop !== 4'(1 << k)) begin
                failures++;
                $display("FAIL rr_pop k=%0d got=%b exp=%b", k, eng_pop, 4'(1 << k));
            end
            if (k > 0) begin
                checks++;
                if (ucq_push !== 1'b1 || ucq_lit !== LW'(k)) begin
                    failures++;
                    $display("FAIL rr_push k=%0d got push=%b lit=%h exp push=1 lit=%h",
                             k, ucq_push, ucq_lit, LW'(k));
                end
            end
            advance();
        end
        eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b1 || ucq_lit !== 8'h04 || stall !== 1'b1) begin
            failures++;
            $display("FAIL rr_last got push=%b lit=%h stall=%b exp push=1 lit=04 stall=1",
                     ucq_push, ucq_lit, stall);
        end
        advance();
    endtask

    task automatic test_dup();
        do_reset();
        eng_valid = 4'b0001; set_lit(0, 8'h05);
        settle(); advance();
        eng_valid = 4'b0100; set_lit(2, 8'h05);
        settle();
        checks++;
        if (eng_pop !== 4'b0100) begin
            failures++;
            $display("FAIL dup_pop got=%b exp=0100", eng_pop);
        end
        advance();
        eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b0 || dup_cnt !== 16'd1) begin
            failures++;
            $display("FAIL dup_drop got push=%b dup=%0d exp push=0 dup=1", ucq_push, dup_cnt);
        end
        advance();
    endtask

    task automatic test_conflict();
        do_reset();
        eng_valid = 4'b0001; set_lit(0, 8'h05);
        settle(); advance();
        eng_valid = 4'b0010; set_lit(1, 8'h85);
        settle();
        checks++;
        if (eng_pop !== 4'b0010) begin
            failures++;
            $display("FAIL conf_pop got=%b exp=0010", eng_pop);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (conflict !== 1'b1 || eng_pop !== '0 || ucq_push !== 1'b0 || stall !== 1'b1) begin
                failures++;
                $display("FAIL conf_hold k=%0d got conf=%b pop=%b push=%b stall=%b exp 1/0/0/1",
                         k, conflict, eng_pop, ucq_push, stall);
            end
            advance();
        end
        conflict_ack = 1'b1;
        settle(); advance();
        conflict_ack = 1'b0;
        settle();
        checks++;
        if (conflict !== 1'b0 || eng_pop !== 4'b0010) begin
            failures++;
            $display("FAIL conf_ack got conf=%b pop=%b exp conf=0 pop=0010", conflict, eng_pop);
        end
        advance();
        eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b1 || ucq_lit !== 8'h85) begin
            failures++;
            $display("FAIL conf_reissue got push=%b lit=%h exp push=1 lit=85", ucq_push, ucq_lit);
        end
        advance();
    endtask

    task automatic test_credits();
        int pushes = 0;
        do_reset();
        eng_valid = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            set_lit(0, LW'(8'h11 + k));
            settle();
            if (ucq_push) pushes++;
            checks++;
            if ((k < 4 && (eng_pop !== 4'b0001 || stall !== 1'b0)) ||
                (k == 4 && (eng_pop !== 4'b0000 || stall !== 1'b1))) begin
                failures++;
                $display("FAIL credit_gate k=%0d got pop=%b stall=%b", k, eng_pop, stall);
            end
            advance();
        end
        checks++;
        if (pushes !== 4) begin
            failures++;
            $display("FAIL credit_pushes got=%0d exp=4", pushes);
        end
        credit_ret = 4'hF;
        settle(); advance();
        credit_ret = '0;
        settle();
        checks++;
        if (eng_pop !== 4'b0001 || stall !== 1'b0) begin
            failures++;
            $display("FAIL credit_resume got pop=%b stall=%b exp pop=0001 stall=0", eng_pop, stall);
        end
        advance();
        eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b1 || ucq_lit !== 8'h15) begin
            failures++;
            $display("FAIL credit_fifth got push=%b lit=%h exp push=1 lit=15", ucq_push, ucq_lit);
        end
        advance();
    endtask

    task automatic test_lvl_clear();
        do_reset();
        eng_valid = 4'b0001; set_lit(0, 8'h05);
        settle(); advance();
        lvl_clear = 1'b1;
        settle();
        checks++;
        if (eng_pop !== '0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL lvl_suppress got pop=%b stall=%b exp pop=0 stall=1", eng_pop, stall);
        end
        advance();
        lvl_clear = 1'b0;
        settle();
        checks++;
        if (eng_pop !== 4'b0001) begin
            failures++;
            $display("FAIL lvl_regrant got=%b exp=0001", eng_pop);
        end
        advance();
        eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b1 || ucq_lit !== 8'h05 || dup_cnt !== 16'd0) begin
            failures++;
            $display("FAIL lvl_reissue got push=%b lit=%h dup=%0d exp 1/05/0",
                     ucq_push, ucq_lit, dup_cnt);
        end
        advance();
    endtask

    task automatic test_hist_full();
        do_reset();
        credit_ret = 4'hF;
        eng_valid  = 4'b0001;
        for (int k = 0; k < CD; k++) begin
            set_lit(0, LW'(8'h21 + k));
            settle();
            checks++;
            if (eng_pop !== 4'b0001) begin
                failures++;
                $display("FAIL full_fill k=%0d got=%b exp=0001", k, eng_pop);
            end
            advance();
        end
        set_lit(0, 8'h29);
        settle();
        checks++;
        if (eng_pop !== '0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL full_block got pop=%b stall=%b exp pop=0 stall=1", eng_pop, stall);
        end
        advance();
        lvl_clear = 1'b1;
        settle(); advance();
        lvl_clear = 1'b0;
        settle();
        checks++;
        if (eng_pop !== 4'b0001 || stall !== 1'b0) begin
            failures++;
            $display("FAIL full_release got pop=%b stall=%b exp pop=0001 stall=0", eng_pop, stall);
        end
        advance();
        eng_valid = '0; credit_ret = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b1 || ucq_lit !== 8'h29) begin
            failures++;
            $display("FAIL full_ninth got push=%b lit=%h exp push=1 lit=29", ucq_push, ucq_lit);
        end
        advance();
    endtask

    task automatic test_reset_midop();
        do_reset();
        eng_valid = 4'b0001; set_lit(0, 8'h31);
        settle(); advance();
        set_lit(0, 8'h32);
        rst = 1'b1;
        settle(); advance();
        rst = 1'b0; eng_valid = '0;
        settle();
        checks++;
        if (ucq_push !== 1'b0 || ucq_lit !== 8'h00 || stall !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset got push=%b lit=%h stall=%b exp 0/00/0",
                     ucq_push, ucq_lit, stall);
        end
        advance();
    endtask

    task automatic test_random();
        int v;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            eng_valid = NE'($urandom);
            for (int e = 0; e < NE; e++) begin
                v = $urandom_range(1, 6);
                if ($urandom_range(0, 9) == 0) set_lit(e, 8'h00);
                else set_lit(e, {1'($urandom), 7'(v)});
            end
            for (int e = 0; e < NE; e++) credit_ret[e] = ($urandom_range(0, 2) == 0);
            lvl_clear    = ($urandom_range(0, 15) == 0);
            conflict_ack = ($urandom_range(0, 3) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            settle();
            checks++;
            if ({eng_pop, stall, ucq_push, ucq_lit, conflict, dup_cnt} !==
                {p_pop, p_stall, m_push, m_lit, m_conf, 16'(m_dup)}) begin
                failures++;
                $display("FAIL random c=%0d got pop=%b st=%b push=%b lit=%h conf=%b dup=%0d exp pop=%b st=%b push=%b lit=%h conf=%b dup=%0d",
                         c, eng_pop, stall, ucq_push, ucq_lit, conflict, dup_cnt,
                         p_pop, p_stall, m_push, m_lit, m_conf, m_dup);
            end
            advance();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_rr();
        test_dup();
        test_conflict();
        test_credits();
        test_lvl_clear();
        test_hist_full();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
